// File: rtl/popcount_frame_accumulator.sv
// rtl/popcount_frame_accumulator.sv - per-word popcount with saturating frame accumulation
//
// Purpose:
//    Counts set bits (or clear bits when count_zeros=1) in every accepted
//    input word. Per-word counts are summed over a frame that ends on
//    in_last, and the frame total is offered on a valid/ready result port.
//    A registered per-word count is also exported.
//
// Ports:
//    clk, rst      clock (rising edge), asynchronous active-high reset
//    clear         synchronous frame abort (drops partial frame or held result)
//    count_zeros   0 = count ones, 1 = count zeros; sampled on each accepted beat
//    in_valid/in_ready/in_data/in_last   input word stream
//    word_valid/word_count               one-cycle pulse with last word's count
//    out_valid/out_ready                 frame result handshake
//    out_count/out_beats/out_sat         frame total, beat count, saturation flag
module popcount_frame_accumulator #(
   parameter int WIDTH  = 8,
   parameter int CNT_W  = $clog2(WIDTH + 1),
   parameter int ACC_W  = 16,
   parameter int BEAT_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              count_zeros,
   input  logic              in_valid,
   input  logic [WIDTH-1:0]  in_data,
   input  logic              in_last,
   output logic              in_ready,
   output logic              word_valid,
   output logic [CNT_W-1:0]  word_count,
   output logic              out_valid,
   output logic [ACC_W-1:0]  out_count,
   output logic [BEAT_W-1:0] out_beats,
   output logic              out_sat,
   input  logic              out_ready
);

   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_HOLD  = 1'b1
   } state_t;

   state_t             r_state;
   state_t             w_state_next;

   logic [ACC_W-1:0]   r_acc;
   logic [BEAT_W-1:0]  r_beats;
   logic               r_sat;
   logic               r_word_valid;
   logic [CNT_W-1:0]   r_word_count;
   logic [ACC_W-1:0]   r_out_count;
   logic [BEAT_W-1:0]  r_out_beats;
   logic               r_out_sat;
   // Holds in_ready low during reset and releases it one edge after rst falls.
   logic               r_rdy_en;

   logic               w_accept;
   logic [WIDTH-1:0]   w_word;
   logic [CNT_W-1:0]   w_pc;
   logic [ACC_W:0]     w_sum;
   logic [ACC_W-1:0]   w_sum_sat;
   logic               w_sat_next;
   logic [BEAT_W-1:0]  w_beats_inc;

   assign in_ready   = r_rdy_en && (r_state == ST_ACCUM);
   assign out_valid  = (r_state == ST_HOLD);
   assign w_accept   = in_valid && in_ready;

   assign word_valid = r_word_valid;
   assign word_count = r_word_count;
   assign out_count  = r_out_count;
   assign out_beats  = r_out_beats;
   assign out_sat    = r_out_sat;

   assign w_word = count_zeros ? ~in_data : in_data;

   always_comb begin
      w_pc = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_pc = w_pc + CNT_W'(w_word[i]);
      end
   end

   // One guard bit catches overflow: acc and pc are each at most 2^ACC_W-1.
   assign w_sum       = {1'b0, r_acc} + (ACC_W + 1)'(w_pc);
   assign w_sum_sat   = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
   assign w_sat_next  = r_sat | w_sum[ACC_W];
   assign w_beats_inc = (&r_beats) ? r_beats : r_beats + BEAT_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_ACCUM;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_ACCUM: begin
            if (!clear && w_accept && in_last) begin
               w_state_next = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (clear || out_ready) begin
               w_state_next = ST_ACCUM;
            end
         end
         default: w_state_next = ST_ACCUM;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdy_en     <= 1'b0;
         r_acc        <= '0;
         r_beats      <= '0;
         r_sat        <= 1'b0;
         r_word_valid <= 1'b0;
         r_word_count <= '0;
         r_out_count  <= '0;
         r_out_beats  <= '0;
         r_out_sat    <= 1'b0;
      end else begin
         r_rdy_en     <= 1'b1;
         // The per-word count reports every accepted beat, even one discarded by clear.
         r_word_valid <= w_accept;
         if (w_accept) begin
            r_word_count <= w_pc;
         end

         if (r_state == ST_ACCUM) begin
            if (clear) begin
               r_acc   <= '0;
               r_beats <= '0;
               r_sat   <= 1'b0;
            end else if (w_accept) begin
               if (in_last) begin
                  r_out_count <= w_sum_sat;
                  r_out_beats <= w_beats_inc;
                  r_out_sat   <= w_sat_next;
                  r_acc       <= '0;
                  r_beats     <= '0;
                  r_sat       <= 1'b0;
               end else begin
                  r_acc   <= w_sum_sat;
                  r_beats <= w_beats_inc;
                  r_sat   <= w_sat_next;
               end
            end
         end
      end
   end

endmodule

// File: doc/popcount_frame_accumulator.md
Name: popcount_frame_accumulator

Overview:
- Streaming, parametrised successor to the 4-input combinational signal counter.
- Counts set bits, or clear bits when `count_zeros`=1, in each accepted WIDTH-bit word.
- Accumulates the per-word counts over a frame delimited by `in_last` and presents the frame total on a valid/ready output.
- Sits between a word source and downstream arithmetic; also exports a registered per-word count.

Parameters:
- WIDTH, 8: bits per input word, ≥1.
- CNT_W, $clog2(WIDTH+1): width of the per-word count.
- ACC_W, 16: width of the frame accumulator, ≥ CNT_W.
- BEAT_W, 8: width of the beat counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- clear  in  1  synchronous frame abort.
- count_zeros  in  1  0 = count ones, 1 = count zeros; sampled per accepted beat.
- in_valid  in  1  input word valid.
- in_data  in  WIDTH  input word.
- in_last  in  1  last word of frame; qualified by the input handshake.
- in_ready  out  1  block can accept a word.
- word_valid  out  1  one-cycle pulse; `word_count` updated.
- word_count  out  CNT_W  count of the last accepted word.
- out_valid  out  1  frame result valid.
- out_count  out  ACC_W  frame total.
- out_beats  out  BEAT_W  words in frame, saturating.
- out_sat  out  1  frame total saturated.
- out_ready  in  1  downstream accepts the result.

Behaviour:
- Reset is asynchronous and active-high, on `rst`; single clock `clk`. Reset values:
  - state = ACCUM.
  - acc = 0, beats = 0, sat = 0.
  - word_valid = 0, word_count = 0.
  - out_valid = 0, out_count = 0, out_beats = 0, out_sat = 0.
  - in_ready = 1 one cycle after `rst` deasserts.
- Accept: a beat is accepted when `in_valid` and `in_ready` are both 1 on a rising edge.
- Per-word count: pc = number of 1 bits in `in_data`, or in ~`in_data` when `count_zeros`=1. Range 0..WIDTH.
- States:
  - ACCUM: `in_ready`=1, `out_valid`=0.
  - HOLD: `in_ready`=0, `out_valid`=1.
- ACCUM, accepted beat:
  - word_count <= pc; word_valid pulses high for exactly the next cycle.
  - sum = acc + pc, zero-extended. If sum > 2^ACC_W-1, the result is 2^ACC_W-1 and sat is set; sat is sticky for the frame.
  - beats increments, saturating at 2^BEAT_W-1.
  - If `in_last`=0: acc <= sum, beats <= beats+1.
  - If `in_last`=1: out_count <= sum, out_beats <= beats+1, out_sat <= final sat. Then acc, beats and sat are cleared, and the state goes to HOLD.
- Latency: `out_valid` rises the cycle after the last beat is accepted. A single-beat frame (`in_last` on the first word) is legal.
- HOLD:
  - out_count, out_beats and out_sat are stable while `out_valid`=1.
  - `in_valid` is ignored.
  - When `out_valid` and `out_ready` are both 1 on an edge: `out_valid` <= 0, state -> ACCUM, `in_ready`=1 the next cycle. There is no same-cycle accept of a new beat.
- `out_ready` while not in HOLD: ignored.
- `clear`=1 in ACCUM:
  - Clears acc, beats and sat; no result is produced.
  - An accepted beat in the same cycle is discarded, except that word_count/word_valid still update.
- `clear`=1 in HOLD: drops `out_valid`, returns to ACCUM, and discards the result.
- `clear` has priority over `in_last`.
- `rst` mid-frame or in HOLD: all state is lost immediately, including a pending result.
- WIDTH=1: pc ∈ {0,1}; CNT_W=1.

Test Plan:
- WIDTH=8, count_zeros=0; frame 0xFF, 0x0F, 0x01 (last), out_ready=1 → word_count 8, 4, 1; out_count=13, out_beats=3, out_sat=0, out_valid for 1 cycle.
- count_zeros=1; single-beat frame 0x81 with in_last → out_count=6, out_beats=1, out_valid the cycle after accept.
- ACC_W=4; frame of three 0xFF beats → out_count=15, out_sat=1. The next frame 0x03 → out_count=2, out_sat=0 (sticky cleared).
- out_ready held 0 for 5 cycles after the result → out_valid, out_count and out_beats stable; in_ready=0; in_valid pulses ignored. out_ready=1 → in_ready=1 the next cycle.
- Mid-frame clear after 0xFF, 0xFF, then frame 0x07 (last) → out_count=3, out_beats=1. Also clear asserted with in_last → no out_valid.
- Assert rst asynchronously (between edges) while in HOLD → out_valid=0, in_ready=0 immediately while rst is high; in_ready=1 the cycle after rst deasserts. A subsequent frame 0xAA (last) → out_count=4.
